// File: rtl/pwm_pkg.sv
// Shared types and constants for the PWM speed capture block.
package pwm_pkg;

   typedef enum logic [1:0] {StIdle, StHigh, StLow} state_e;

   localparam int unsigned CNT_W       = 10;
   localparam int unsigned SPEED_MAX   = 200;
   localparam int unsigned PERIOD_NOM  = 606;
   localparam int unsigned SPEED_SCALE = 3;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == '1) ? v : v + 1'b1;
   endfunction

   // High time to speed: the generator encodes speed as 3 clk cycles of high time per unit.
   function automatic logic [7:0] speed_of(input logic [CNT_W-1:0] h);
      logic [CNT_W-1:0] q;
      q = h / CNT_W'(SPEED_SCALE);
      return (q > CNT_W'(SPEED_MAX)) ? 8'(SPEED_MAX) : q[7:0];
   endfunction

endpackage

// File: rtl/pwm_edge_det.sv
// Synchronizer, optional glitch filter (PWM_CAPTURE_GLITCH_FILTER_EN) and edge detector
// for the asynchronous PWM input.
module pwm_edge_det (
   input  logic clk,
   input  logic rst,
   input  logic pwm_in,
   output logic level,
   output logic rise,
   output logic fall
);

   logic sync1_q, sync_q, prev_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1_q <= 1'b0;
         sync_q  <= 1'b0;
         prev_q  <= 1'b0;
      end else begin
         sync1_q <= pwm_in;
         sync_q  <= sync1_q;
         prev_q  <= level;
      end
   end

`ifdef PWM_CAPTURE_GLITCH_FILTER_EN
   logic hist1_q, hist2_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hist1_q <= 1'b0;
         hist2_q <= 1'b0;
      end else begin
         hist1_q <= sync_q;
         hist2_q <= hist1_q;
      end
   end

   // Level only moves once three consecutive synchronized samples agree.
   assign level = (sync_q == hist1_q && hist1_q == hist2_q) ? sync_q : prev_q;
`else
   assign level = sync_q;
`endif

   assign rise = level & ~prev_q;
   assign fall = ~level & prev_q;

endmodule

// File: rtl/pwm_capture.sv
// PWM speed decoder: measures high time and period of pwm_in, reports speed, period
// errors and idle-line timeout. Optional input glitch filter: PWM_CAPTURE_GLITCH_FILTER_EN.
module pwm_capture #(
   parameter int unsigned PERIOD_NOM  = pwm_pkg::PERIOD_NOM,
   parameter int unsigned PERIOD_TOL  = 6,
   parameter int unsigned TIMEOUT_CYC = 1023
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       pwm_in,
   output logic [7:0] speed_out,
   output logic       speed_valid,
   output logic       period_err,
   output logic       timeout
);
   import pwm_pkg::*;

   localparam logic [CNT_W-1:0] PerMin   = CNT_W'(PERIOD_NOM - PERIOD_TOL);
   localparam logic [CNT_W-1:0] PerMax   = CNT_W'(PERIOD_NOM + PERIOD_TOL);
   localparam logic [CNT_W-1:0] IdleLast = CNT_W'(TIMEOUT_CYC - 1);

   logic level, rise, fall;

   state_e           state_q, state_d;
   logic [CNT_W-1:0] per_q, per_d, high_q, high_d, idle_q, idle_d;
   logic [7:0]       speed_q, speed_d;
   logic             valid_q, valid_d, err_q, err_d, timeout_q, timeout_d;
   logic             fire, close;

   pwm_edge_det u_edge_det (
      .clk    (clk),
      .rst    (rst),
      .pwm_in (pwm_in),
      .level  (level),
      .rise   (rise),
      .fall   (fall)
   );

   // Fires once per idle stretch; timeout_q blocks re-arming until the next rise.
   assign fire = ~rise & ~fall & ~timeout_q & (idle_q == IdleLast);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= StIdle;
         per_q     <= '0;
         high_q    <= '0;
         idle_q    <= '0;
         speed_q   <= '0;
         valid_q   <= 1'b0;
         err_q     <= 1'b0;
         timeout_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         per_q     <= per_d;
         high_q    <= high_d;
         idle_q    <= idle_d;
         speed_q   <= speed_d;
         valid_q   <= valid_d;
         err_q     <= err_d;
         timeout_q <= timeout_d;
      end
   end

   always_comb begin
      state_d = state_q;
      if (fire) begin
         state_d = StIdle;
      end else begin
         unique case (state_q)
            StIdle:  if (rise) state_d = StHigh;
            StHigh:  if (fall) state_d = StLow;
            StLow:   if (rise) state_d = StHigh;
            default: state_d = StIdle;
         endcase
      end
   end

   always_comb begin
      per_d     = rise ? CNT_W'(1) : sat_inc(per_q);
      high_d    = high_q;
      idle_d    = (rise | fall) ? '0 : sat_inc(idle_q);
      speed_d   = speed_q;
      valid_d   = 1'b0;
      err_d     = 1'b0;
      timeout_d = timeout_q;
      close     = (state_q == StLow) & rise;

      if (rise) begin
         high_d = CNT_W'(1);
      end else if (state_q == StHigh && level) begin
         high_d = sat_inc(high_q);
      end

      if (fire) begin
         timeout_d = 1'b1;
         speed_d   = '0;
         valid_d   = 1'b1;
      end else if (close) begin
         if (per_q >= PerMin && per_q <= PerMax) begin
            speed_d = speed_of(high_q);
            valid_d = 1'b1;
         end else begin
            err_d = 1'b1;
         end
      end

      if (rise) timeout_d = 1'b0;
   end

   assign speed_out   = speed_q;
   assign speed_valid = valid_q;
   assign period_err  = err_q;
   assign timeout     = timeout_q;

endmodule

// File: tb/tb_pwm_capture.sv
// Directed bench for pwm_capture: speed decode, clamp/floor, tolerance edges, period
// error, async reset mid-measurement and idle timeout.
module tb_pwm_capture;

   logic       clk;
   logic       rst;
   logic       pwm_in;
   logic [7:0] speed_out;
   logic       speed_valid;
   logic       period_err;
   logic       timeout;

   int vectors     = 0;
   int miscompares = 0;
   int n_valid     = 0;
   int n_err       = 0;
   int n_both      = 0;
   int last_speed  = 0;
   int v0, e0;

`ifdef PWM_CAPTURE_GLITCH_FILTER_EN
   localparam int FiltLat = 2;
`else
   localparam int FiltLat = 0;
`endif

   pwm_capture dut (
      .clk         (clk),
      .rst         (rst),
      .pwm_in      (pwm_in),
      .speed_out   (speed_out),
      .speed_valid (speed_valid),
      .period_err  (period_err),
      .timeout     (timeout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (speed_valid) begin
         n_valid    <= n_valid + 1;
         last_speed <= int'(speed_out);
      end
      if (period_err) n_err <= n_err + 1;
      if (speed_valid && period_err) n_both <= n_both + 1;
   end

   task automatic check(input string tag, input int obs, input int exp);
      vectors++;
      assert (obs === exp)
      else begin
         miscompares++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Hold pwm_in at lvl for n clk cycles; called and returns on a negedge.
   task automatic drive(input logic lvl, input int n);
      pwm_in = lvl;
      repeat (n) @(negedge clk);
   endtask

   initial begin
      rst    = 1'b1;
      pwm_in = 1'b0;
      repeat (3) @(negedge clk);
      check("reset speed_out", int'(speed_out), 0);
      check("reset speed_valid", int'(speed_valid), 0);
      check("reset period_err", int'(period_err), 0);
      check("reset timeout", int'(timeout), 0);
      rst = 1'b0;
      drive(1'b0, 5);

      // 300/306: first rise only starts, later rises report 100
      v0 = n_valid;
      drive(1'b1, 300); drive(1'b0, 306);
      check("first rise no output", n_valid - v0, 0);
      drive(1'b1, 300); drive(1'b0, 306);
      check("second rise valid", n_valid - v0, 1);
      check("300/306 speed", int'(speed_out), 100);
      check("300/306 pulse speed", last_speed, 100);

      drive(1'b1, 600); drive(1'b0, 6);
      drive(1'b1, 302); drive(1'b0, 304);
      check("600/606 speed", int'(speed_out), 200);
      check("valid count", n_valid - v0, 3);
      drive(1'b1, 603); drive(1'b0, 3);
      check("302 floor speed", int'(speed_out), 100);
      drive(1'b1, 300); drive(1'b0, 250);
      check("603 clamp speed", int'(speed_out), 200);

      // Period 550 closes as an error
      v0 = n_valid; e0 = n_err;
      drive(1'b1, 300); drive(1'b0, 306);
      check("550 period_err", n_err - e0, 1);
      check("550 no valid", n_valid - v0, 0);
      check("550 speed held", int'(speed_out), 200);

      // Tolerance edges: 612 and 600 accepted, 613 and 599 rejected
      drive(1'b1, 303); drive(1'b0, 309);
      drive(1'b1, 300); drive(1'b0, 313);
      check("612 accepted speed", int'(speed_out), 101);
      e0 = n_err;
      drive(1'b1, 306); drive(1'b0, 294);
      check("613 period_err", n_err - e0, 1);
      check("613 speed held", int'(speed_out), 101);
      drive(1'b1, 300); drive(1'b0, 299);
      check("600 accepted speed", int'(speed_out), 102);
      e0 = n_err;
      drive(1'b1, 300); drive(1'b0, 306);
      check("599 period_err", n_err - e0, 1);
      check("599 speed held", int'(speed_out), 102);

`ifdef PWM_CAPTURE_GLITCH_FILTER_EN
      v0 = n_valid; e0 = n_err;
      drive(1'b1, 100); drive(1'b0, 1); drive(1'b1, 199); drive(1'b0, 306);
      drive(1'b1, 300);
      check("glitch valid count", n_valid - v0, 2);
      check("glitch no period_err", n_err - e0, 0);
      check("glitch speed", int'(speed_out), 100);
      drive(1'b0, 306);
`endif

      // Async reset mid-HIGH
      drive(1'b1, 100);
      check("pre-reset speed", int'(speed_out), 100);
      #1 rst = 1'b1;
      pwm_in = 1'b0;
      #1;
      check("async reset speed", int'(speed_out), 0);
      repeat (3) @(negedge clk);
      rst = 1'b0;
      drive(1'b0, 10);
      v0 = n_valid; e0 = n_err;
      drive(1'b1, 150); drive(1'b0, 456);
      check("post-reset no valid", n_valid - v0, 0);
      check("post-reset no err", n_err - e0, 0);
      check("post-reset speed", int'(speed_out), 0);
      drive(1'b1, 150);
      check("post-reset valid", n_valid - v0, 1);
      check("post-reset speed 50", int'(speed_out), 50);
      drive(1'b0, 456);
      drive(1'b1, 150);
      check("pre-timeout speed", int'(speed_out), 50);

      // Idle line: fall then 1100 low cycles; rise of timeout lands 1026 negedges after the
      // drive (2 sync + 1 detect cycle + 1023 edge-free cycles)
      v0 = n_valid;
      pwm_in = 1'b0;
      repeat (1025 + FiltLat) @(negedge clk);
      check("timeout not yet", int'(timeout), 0);
      @(negedge clk);
      check("timeout set", int'(timeout), 1);
      check("timeout speed", int'(speed_out), 0);
      repeat (74) @(negedge clk);
      check("timeout single valid", n_valid - v0, 1);
      check("timeout held", int'(timeout), 1);
      pwm_in = 1'b1;
      repeat (2 + FiltLat) @(negedge clk);
      check("timeout before clear", int'(timeout), 1);
      @(negedge clk);
      check("timeout cleared", int'(timeout), 0);
      check("valid/err overlap", n_both, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
